// File: rtl/us_cmd_packer_if.sv
// Groups the TRN RX stream and upstream command FIFO write port of us_cmd_packer.
// slave: the packer side; master: the endpoint/FIFO environment side.
interface us_cmd_packer_if;
    logic [31:0]  trn_rd;
    logic         trn_rsof_n;
    logic         trn_reof_n;
    logic         trn_rsrc_rdy_n;
    logic         trn_rdst_rdy_n;
    logic         trn_rerrfwd_n;
    logic [6:0]   trn_rbar_hit_n;
    logic         us_cmd_fifo_wr_en_o;
    logic [127:0] us_cmd_fifo_din_o;
    logic         us_cmd_fifo_full_i;

    modport slave (
        input  trn_rd, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rerrfwd_n, trn_rbar_hit_n,
        input  us_cmd_fifo_full_i,
        output trn_rdst_rdy_n, us_cmd_fifo_wr_en_o, us_cmd_fifo_din_o
    );

    modport master (
        output trn_rd, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rerrfwd_n, trn_rbar_hit_n,
        output us_cmd_fifo_full_i,
        input  trn_rdst_rdy_n, us_cmd_fifo_wr_en_o, us_cmd_fifo_din_o
    );
endinterface

// File: rtl/us_cmd_packer.sv
// Packs 3DW MRd32/MWr32 TLPs from the TRN RX stream into 128-bit upstream FIFO commands.
// Define US_CMD_DROP_CNT_EN to implement the saturating dropped-TLP counter.
module us_cmd_packer #(
    parameter logic [6:0]  BAR_MASK   = 7'b0000001,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    us_cmd_packer_if.slave        bus,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);
    typedef enum logic [2:0] {StIdle, StHdr1, StHdr2, StData, StPush, StDiscard} state_e;

    state_e      state_q, state_d;
    logic        rdst_rdy_n_q, rdst_rdy_n_d;
    logic [31:0] dw0_q, dw0_d, dw1_q, dw1_d, dw2_q, dw2_d, data_q, data_d;
    logic        err_q, err_d;
    logic [1:0]  drop_inc;
    logic        beat, sof, eof, err_beat, err_any, dw0_ok, is_wr;

    assign beat     = ~bus.trn_rsrc_rdy_n & ~rdst_rdy_n_q;
    assign sof      = ~bus.trn_rsof_n;
    assign eof      = ~bus.trn_reof_n;
    assign err_beat = ~bus.trn_rerrfwd_n;
    assign err_any  = err_q | err_beat;
    assign is_wr    = dw0_q[30];
    assign dw0_ok   = ((bus.trn_rd[30:24] == 7'h00) || (bus.trn_rd[30:24] == 7'h40)) &&
                      (bus.trn_rd[9:0] == 10'd1) &&
                      ((~bus.trn_rbar_hit_n & BAR_MASK) != 7'd0) && !err_beat;

    always_comb begin
        state_d  = state_q;
        dw0_d    = dw0_q;
        dw1_d    = dw1_q;
        dw2_d    = dw2_q;
        data_d   = data_q;
        err_d    = err_q;
        drop_inc = 2'd0;
        if (state_q == StPush) begin
            if (!bus.us_cmd_fifo_full_i) state_d = StIdle;
        end else if (beat) begin
            if (sof) begin
                // A SOF outside IDLE aborts the TLP in flight; this beat restarts capture.
                if (state_q != StIdle) drop_inc = drop_inc + 2'd1;
                dw0_d  = bus.trn_rd;
                data_d = 32'h0;
                err_d  = err_beat;
                if (dw0_ok && !eof) begin
                    state_d = StHdr1;
                end else if (eof) begin
                    state_d  = StIdle;
                    drop_inc = drop_inc + 2'd1;
                end else begin
                    state_d = StDiscard;
                end
            end else begin
                err_d = err_any;
                unique case (state_q)
                    StHdr1: begin
                        dw1_d = bus.trn_rd;
                        if (eof) begin
                            state_d  = StIdle;
                            drop_inc = 2'd1;
                        end else begin
                            state_d = StHdr2;
                        end
                    end
                    StHdr2: begin
                        dw2_d = bus.trn_rd;
                        if (!err_any && !is_wr && eof) begin
                            state_d = StPush;
                        end else if (!err_any && is_wr && !eof) begin
                            state_d = StData;
                        end else if (eof) begin
                            state_d  = StIdle;
                            drop_inc = 2'd1;
                        end else begin
                            state_d = StDiscard;
                        end
                    end
                    StData: begin
                        data_d = bus.trn_rd;
                        if (eof && !err_any) begin
                            state_d = StPush;
                        end else if (eof) begin
                            state_d  = StIdle;
                            drop_inc = 2'd1;
                        end else begin
                            state_d = StDiscard;
                        end
                    end
                    StDiscard: begin
                        if (eof) begin
                            state_d  = StIdle;
                            drop_inc = 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        rdst_rdy_n_d = (state_d == StPush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rdst_rdy_n_q <= 1'b1;
            dw0_q        <= '0;
            dw1_q        <= '0;
            dw2_q        <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdst_rdy_n_q <= rdst_rdy_n_d;
            dw0_q        <= dw0_d;
            dw1_q        <= dw1_d;
            dw2_q        <= dw2_d;
            data_q       <= data_d;
            err_q        <= err_d;
        end
    end

    assign bus.trn_rdst_rdy_n      = rdst_rdy_n_q;
    assign bus.us_cmd_fifo_wr_en_o = (state_q == StPush) & ~bus.us_cmd_fifo_full_i;
    assign bus.us_cmd_fifo_din_o   = {dw0_q, dw1_q, dw2_q, data_q};

`ifdef US_CMD_DROP_CNT_EN
    logic [DROP_CNT_W:0]   drop_sum;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Up to two drops in one cycle: an aborted TLP plus an unsupported single-beat SOF.
    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + {{(DROP_CNT_W - 1){1'b0}}, drop_inc};
        drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    logic unused_drop_inc;
    assign unused_drop_inc = ^drop_inc;
    assign drop_cnt_o      = '0;
`endif
endmodule

// File: tb/tb_us_cmd_packer.sv
// Directed self-checking bench for us_cmd_packer: packing, backpressure, drops, faults, reset.
`timescale 1ns/1ps
module tb_us_cmd_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] drop_cnt;
    int          checks = 0;
    int          failures = 0;
    int          wr_cnt = 0;
    int          base_wr;
    int          exp_drop = 0;
    logic [127:0] last_din = '0;

`ifdef US_CMD_DROP_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif
    localparam logic [6:0] Bar0 = 7'b1111110;

    us_cmd_packer_if bus ();

    us_cmd_packer #(
        .BAR_MASK   (7'b0000001),
        .DROP_CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .drop_cnt_o (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.us_cmd_fifo_wr_en_o === 1'b1) begin
            wr_cnt++;
            last_din = bus.us_cmd_fifo_din_o;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] d, input bit sof, input bit eof, input bit err,
                              input logic [6:0] bar_n, input bit gap);
        int guard;
        if (gap) begin
            bus.trn_rsrc_rdy_n = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.trn_rd         = d;
        bus.trn_rsof_n     = ~sof;
        bus.trn_reof_n     = ~eof;
        bus.trn_rerrfwd_n  = ~err;
        bus.trn_rbar_hit_n = bar_n;
        bus.trn_rsrc_rdy_n = 1'b0;
        guard = 0;
        @(negedge clk);
        while (bus.trn_rdst_rdy_n !== 1'b0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) check_eq("beat_timeout", 128'(guard), 128'd0);
        @(posedge clk);
        #1;
        bus.trn_rsrc_rdy_n = 1'b1;
        bus.trn_rsof_n     = 1'b1;
        bus.trn_reof_n     = 1'b1;
        bus.trn_rerrfwd_n  = 1'b1;
        bus.trn_rbar_hit_n = '1;
    endtask

    task automatic send_tlp(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] d3, input int n, input logic [6:0] bar_n,
                            input int err_idx, input bit gap);
        logic [31:0] w [4];
        w[0] = d0;
        w[1] = d1;
        w[2] = d2;
        w[3] = d3;
        for (int i = 0; i < n; i++) begin
            drive_beat(w[i], i == 0, i == n - 1, i == err_idx, bar_n, gap && (i > 0));
        end
    endtask

    initial begin
        bus.trn_rd             = '0;
        bus.trn_rsof_n         = 1'b1;
        bus.trn_reof_n         = 1'b1;
        bus.trn_rsrc_rdy_n     = 1'b1;
        bus.trn_rerrfwd_n      = 1'b1;
        bus.trn_rbar_hit_n     = '1;
        bus.us_cmd_fifo_full_i = 1'b0;
        #12;
        @(negedge clk);
        check_eq("rst_rdy_n", 128'(bus.trn_rdst_rdy_n), 128'd1);
        check_eq("rst_wr_en", 128'(bus.us_cmd_fifo_wr_en_o), 128'd0);
        check_eq("rst_din", bus.us_cmd_fifo_din_o, 128'd0);
        check_eq("rst_drop", 128'(drop_cnt), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // MRd32, BAR0, FIFO empty: write in the cycle right after EOF
        send_tlp(32'h0000_0001, 32'h0100_050F, 32'h0000_0010, 32'h0, 3, Bar0, -1, 1'b0);
        @(negedge clk);
        check_eq("mrd_wr_en", 128'(bus.us_cmd_fifo_wr_en_o), 128'd1);
        check_eq("mrd_rdy_n_hi", 128'(bus.trn_rdst_rdy_n), 128'd1);
        check_eq("mrd_din", bus.us_cmd_fifo_din_o, 128'h00000001_0100050F_00000010_00000000);
        @(negedge clk);
        check_eq("mrd_wr_en_off", 128'(bus.us_cmd_fifo_wr_en_o), 128'd0);
        check_eq("mrd_rdy_n_lo", 128'(bus.trn_rdst_rdy_n), 128'd0);
        idle(2);
        check_eq("mrd_wr_cnt", 128'(wr_cnt), 128'd1);

        // MWr32
        send_tlp(32'h4000_0001, 32'h0100_050F, 32'h0000_0020, 32'hDEAD_BEEF, 4, Bar0, -1, 1'b0);
        idle(3);
        check_eq("mwr_wr_cnt", 128'(wr_cnt), 128'd2);
        check_eq("mwr_data", 128'(last_din[31:0]), 128'hDEADBEEF);
        check_eq("mwr_addr", 128'(last_din[63:32]), 128'h20);

        // Backpressure: full for 5 cycles after EOF
        bus.us_cmd_fifo_full_i = 1'b1;
        send_tlp(32'h0000_0001, 32'h0200_070F, 32'h0000_0030, 32'h0, 3, Bar0, -1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_rdy_n", 128'(bus.trn_rdst_rdy_n), 128'd1);
            check_eq("bp_wr_en", 128'(bus.us_cmd_fifo_wr_en_o), 128'd0);
            check_eq("bp_din", bus.us_cmd_fifo_din_o, 128'h00000001_0200070F_00000030_00000000);
            @(posedge clk);
            #1;
        end
        bus.us_cmd_fifo_full_i = 1'b0;
        @(negedge clk);
        check_eq("bp_wr_release", 128'(bus.us_cmd_fifo_wr_en_o), 128'd1);
        idle(1);
        send_tlp(32'h0000_0001, 32'h0100_050F, 32'h0000_0044, 32'h0, 3, Bar0, -1, 1'b0);
        idle(3);
        check_eq("bp_wr_cnt", 128'(wr_cnt), 128'd4);
        check_eq("bp_next_din", last_din, 128'h00000001_0100050F_00000044_00000000);

        // Drops: length 2, BAR1 only, error-forward on DW2, 4DW MRd64
        base_wr = wr_cnt;
        drive_beat(32'h4000_0002, 1'b1, 1'b0, 1'b0, Bar0, 1'b0);
        drive_beat(32'h0100_050F, 1'b0, 1'b0, 1'b0, Bar0, 1'b0);
        drive_beat(32'h0000_0020, 1'b0, 1'b0, 1'b0, Bar0, 1'b0);
        drive_beat(32'h1111_1111, 1'b0, 1'b0, 1'b0, Bar0, 1'b0);
        drive_beat(32'h2222_2222, 1'b0, 1'b1, 1'b0, Bar0, 1'b0);
        send_tlp(32'h0000_0001, 32'h0100_050F, 32'h0000_0010, 32'h0, 3, 7'b1111101, -1, 1'b0);
        send_tlp(32'h0000_0001, 32'h0100_050F, 32'h0000_0010, 32'h0, 3, Bar0, 2, 1'b0);
        send_tlp(32'h2000_0001, 32'h0100_050F, 32'h0000_0000, 32'h10, 4, Bar0, -1, 1'b0);
        idle(3);
        exp_drop = CntEn ? 4 : 0;
        check_eq("drop_no_wr", 128'(wr_cnt), 128'(base_wr));
        check_eq("drop_cnt4", 128'(drop_cnt), 128'(exp_drop));
        send_tlp(32'h0000_0001, 32'h0400_010F, 32'h0000_0060, 32'h0, 3, Bar0, -1, 1'b0);
        idle(3);
        check_eq("drop_after_wr", 128'(wr_cnt), 128'(base_wr + 1));
        check_eq("drop_after_din", last_din, 128'h00000001_0400010F_00000060_00000000);

        // SOF arriving while in HDR2
        drive_beat(32'h0000_0001, 1'b1, 1'b0, 1'b0, Bar0, 1'b0);
        drive_beat(32'h0100_050F, 1'b0, 1'b0, 1'b0, Bar0, 1'b0);
        send_tlp(32'h0000_0001, 32'h0300_0A0F, 32'h0000_0050, 32'h0, 3, Bar0, -1, 1'b0);
        idle(3);
        exp_drop = CntEn ? 5 : 0;
        check_eq("abort_drop", 128'(drop_cnt), 128'(exp_drop));
        check_eq("abort_wr_cnt", 128'(wr_cnt), 128'(base_wr + 2));
        check_eq("abort_din", last_din, 128'h00000001_03000A0F_00000050_00000000);

        // rsrc_rdy_n toggled every other beat
        send_tlp(32'h4000_0001, 32'h0100_050F, 32'h0000_0020, 32'hDEAD_BEEF, 4, Bar0, -1, 1'b1);
        idle(3);
        check_eq("gap_wr_cnt", 128'(wr_cnt), 128'(base_wr + 3));
        check_eq("gap_din", last_din, 128'h40000001_0100050F_00000020_DEADBEEF);

        // Reset after HDR1 of an MWr
        base_wr = wr_cnt;
        drive_beat(32'h4000_0001, 1'b1, 1'b0, 1'b0, Bar0, 1'b0);
        drive_beat(32'h0100_050F, 1'b0, 1'b0, 1'b0, Bar0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_rdy_n", 128'(bus.trn_rdst_rdy_n), 128'd1);
        check_eq("mid_rst_wr_en", 128'(bus.us_cmd_fifo_wr_en_o), 128'd0);
        check_eq("mid_rst_din", bus.us_cmd_fifo_din_o, 128'd0);
        check_eq("mid_rst_drop", 128'(drop_cnt), 128'd0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        drive_beat(32'h0000_0020, 1'b0, 1'b0, 1'b0, Bar0, 1'b0);
        drive_beat(32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, Bar0, 1'b0);
        idle(3);
        check_eq("mid_rst_no_wr", 128'(wr_cnt), 128'(base_wr));
        send_tlp(32'h0000_0001, 32'h0500_020F, 32'h0000_0070, 32'h0, 3, Bar0, -1, 1'b0);
        idle(3);
        check_eq("post_rst_wr_cnt", 128'(wr_cnt), 128'(base_wr + 1));
        check_eq("post_rst_din", last_din, 128'h00000001_0500020F_00000070_00000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/us_cmd_packer.md
Name: us_cmd_packer

Overview:
- Upstream stage of the command-processing FSM.
- Receives PCIe request TLPs from the Spartan-6 endpoint 32-bit TRN RX interface.
- Packs each supported 3DW memory request into one 128-bit command word and writes it into the upstream command FIFO.
- Filters out unsupported and malformed TLPs, which never reach the FIFO.

Parameters:
- BAR_MASK, 7'b0000001, bit i set = TLPs hitting BAR i are accepted.
- DROP_CNT_W, 16, width of the dropped-TLP counter.

Ports:
- clk  in  1  system clock (TRN clock domain)
- rst_n  in  1  asynchronous active-low reset
- trn_rd  in  32  RX data DW
- trn_rsof_n  in  1  start of frame, active low
- trn_reof_n  in  1  end of frame, active low
- trn_rsrc_rdy_n  in  1  source ready, active low
- trn_rdst_rdy_n  out  1  destination ready, active low, registered
- trn_rerrfwd_n  in  1  poisoned/error-forward, active low, sampled on any beat
- trn_rbar_hit_n  in  7  BAR hit, active low, sampled on the SOF beat
- us_cmd_fifo_wr_en_o  out  1  FIFO write strobe
- us_cmd_fifo_din_o  out  128  command word
- us_cmd_fifo_full_i  in  1  FIFO full
- drop_cnt_o  out  DROP_CNT_W  count of dropped TLPs

Behaviour:
- Beat accepted when trn_rsrc_rdy_n==0 and trn_rdst_rdy_n==0.
- Command word layout:
  - [127:96] header DW0
  - [95:64] DW1 (requester ID, tag, byte enables)
  - [63:32] DW2 (address)
  - [31:0] write data for MWr32; 32'h0 for MRd32
- Supported TLPs:
  - DW0[30:24]==7'h00 (MRd32) or 7'h40 (MWr32).
  - Length DW0[9:0]==10'd1.
  - (~trn_rbar_hit_n & BAR_MASK) != 0.
  - No beat with trn_rerrfwd_n==0.
- States: IDLE, HDR1, HDR2, DATA, PUSH, DISCARD.
- IDLE:
  - Accepted beat with SOF: latch DW0 and BAR hit, then go to HDR1. If DW0 is unsupported, go to DISCARD instead; if that beat also has EOF, count a drop and stay in IDLE.
  - Accepted beat without SOF: ignored, not counted.
- HDR1: latch DW1, then go to HDR2.
- HDR2: latch DW2, then:
  - MRd32 with EOF: go to PUSH.
  - MWr32 without EOF: go to DATA.
  - Any other EOF combination: drop. If EOF is present, go to IDLE; otherwise go to DISCARD.
- DATA: latch data DW. EOF present: go to PUSH; otherwise go to DISCARD (counted).
- DISCARD:
  - Consume beats until EOF, then go to IDLE.
  - The drop is counted once, on the EOF beat, or on entry if it was detected on an EOF beat.
- PUSH:
  - trn_rdst_rdy_n=1.
  - us_cmd_fifo_wr_en_o = (state==PUSH) & ~us_cmd_fifo_full_i; combinational from state, single-cycle per write.
  - On the write, go to IDLE.
  - While full, hold PUSH with din stable; no data is lost.
- trn_rdst_rdy_n register: next value = (next_state==PUSH).
- Latency:
  - EOF accepted in cycle N: PUSH and rdst_rdy_n=1 in N+1; wr_en in N+1 if not full.
  - rdst_rdy_n=0 again in N+2. One bubble per TLP.
- Error handling:
  - Error-forward on any beat of a TLP forces a drop; the frame is consumed through EOF.
  - SOF arriving in HDR1/HDR2/DATA/DISCARD: count a drop for the aborted TLP, then restart capture with this beat as DW0.
  - trn_rsrc_rdy_n high: state and latches hold.
- drop_cnt_o: saturates at all ones; no wrap.
- Reset values (asynchronous): state=IDLE, trn_rdst_rdy_n=1, us_cmd_fifo_din_o=0, us_cmd_fifo_wr_en_o=0, drop_cnt_o=0.
- Reset mid-TLP abandons the TLP with no write. After reset release, remaining beats lacking SOF are ignored.

Optional Feature:
- US_CMD_DROP_CNT_EN defined: drop counter implemented as above.
- Not defined: no counter logic; drop_cnt_o tied to 0; drop behaviour otherwise unchanged.

Test Plan:
- MRd32: DW0=32'h0000_0001, DW1=32'h0100_050F, DW2=32'h0000_0010, BAR0 hit, FIFO empty -> one wr_en pulse with din=128'h00000001_0100050F_00000010_00000000 two cycles after SOF+2 beats.
- MWr32: DW0=32'h4000_0001, addr 32'h0000_0020, data 32'hDEAD_BEEF -> din[31:0]=32'hDEADBEEF, din[63:32]=32'h20, exactly one wr_en.
- Backpressure: us_cmd_fifo_full_i=1 for 5 cycles after EOF -> trn_rdst_rdy_n stays 1 and din stable for those cycles; wr_en fires in the first cycle after full drops; a following TLP is accepted correctly.
- Drops: MWr with length 2, BAR1 hit only, error-forward on DW2, 4DW MRd64 (7'h20) -> no wr_en, drop_cnt_o=4; a following valid MRd is still written.
- Protocol faults: SOF mid-HDR2 -> drop_cnt +1 and the new TLP is written; trn_rsrc_rdy_n toggled every other beat -> same output as the back-to-back case.
- Reset mid-MWr after HDR1 -> outputs at reset values, no write; next valid TLP written. With US_CMD_DROP_CNT_EN undefined, the drop test yields drop_cnt_o=0.
